// File: rtl/iir_inverse.sv
// Inverse of the first-order IIR filter y[n] = KX*x[n-1] - KY*y[n-1].
// It recovers x as (y[n] + KY*y[n-1]) / KX with a bit-serial restoring divider.
module iir_inverse #(
  parameter int                 IN_W  = 18,
  parameter int                 OUT_W = 8,
  parameter int                 KX    = 5,
  parameter logic signed [7:0]  KY    = 8'sd1,
  parameter int                 SUM_W = IN_W + 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  data_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_err
);

  if (KX <= 0) begin : g_bad_kx
    $error("iir_inverse: KX must be greater than zero");
  end

  // The remainder is always below KX, so after the shift it stays below 2*KX.
  localparam int REM_W = $clog2(KX + 1) + 1;
  localparam int CNT_W = $clog2(SUM_W + 1);
  localparam logic [REM_W-1:0]        KX_R = REM_W'(KX);
  localparam logic signed [SUM_W-1:0] KY_S = SUM_W'(KY);
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] MINV = -MAXV - SUM_W'(1);

  typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;

  state_t                    state_reg, state_next;
  logic signed [IN_W-1:0]    y_prev_reg;
  logic [SUM_W-1:0]          dvd_reg;
  logic [SUM_W-1:0]          quot_reg;
  logic                      neg_reg;
  logic [REM_W-1:0]          rem_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic signed [OUT_W-1:0]   data_out_reg;
  logic                      out_valid_reg;
  logic                      out_err_reg;

  logic                      accept;
  logic                      last_step;
  logic signed [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]          sum_mag;
  logic [REM_W-1:0]          rem_sh;
  logic [REM_W-1:0]          rem_step;
  logic                      qbit;
  logic [SUM_W-1:0]          quot_step;
  logic signed [SUM_W-1:0]   q_signed;
  logic                      sat_hi;
  logic                      sat_lo;
  logic signed [OUT_W-1:0]   res;
  logic                      res_err;

  assign in_ready  = (state_reg == IDLE);
  assign accept    = in_valid & in_ready;
  assign last_step = (state_reg == DIV) && (cnt_reg == CNT_W'(SUM_W - 1));

  assign data_out  = data_out_reg;
  assign out_valid = out_valid_reg;
  assign out_err   = out_err_reg;

  // The sum is wide enough that the sign-magnitude split cannot overflow.
  always_comb begin
    sum     = SUM_W'(data_in) + SUM_W'(y_prev_reg) * KY_S;
    sum_mag = sum[SUM_W-1] ? SUM_W'(-sum) : SUM_W'(sum);
  end

  always_comb begin
    rem_sh = {rem_reg[REM_W-2:0], dvd_reg[SUM_W-1]};
    if (rem_sh >= KX_R) begin
      rem_step = rem_sh - KX_R;
      qbit     = 1'b1;
    end else begin
      rem_step = rem_sh;
      qbit     = 1'b0;
    end
    quot_step = {quot_reg[SUM_W-2:0], qbit};
    q_signed  = neg_reg ? -$signed(quot_step) : $signed(quot_step);
    sat_hi    = (q_signed > MAXV);
    sat_lo    = (q_signed < MINV);
    if (sat_hi)      res = MAXV[OUT_W-1:0];
    else if (sat_lo) res = MINV[OUT_W-1:0];
    else             res = q_signed[OUT_W-1:0];
    res_err = (rem_step != '0) | sat_hi | sat_lo;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = DIV;
      DIV:     if (last_step) state_next = OUT;
      OUT:     if (out_valid_reg && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_prev_reg    <= '0;
      dvd_reg       <= '0;
      quot_reg      <= '0;
      neg_reg       <= 1'b0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_err_reg   <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            dvd_reg    <= sum_mag;
            neg_reg    <= sum[SUM_W-1];
            y_prev_reg <= data_in;
            quot_reg   <= '0;
            rem_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        DIV: begin
          dvd_reg  <= {dvd_reg[SUM_W-2:0], 1'b0};
          rem_reg  <= rem_step;
          quot_reg <= quot_step;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          if (last_step) begin
            data_out_reg  <= res;
            out_err_reg   <= res_err;
            out_valid_reg <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: out_valid_reg <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_inverse.sv
// Bench for iir_inverse: table-driven directed vectors, then random samples
// checked against an arithmetic model and a filter-driven recovery stream.
module tb_iir_inverse;

  localparam int IN_W  = 18;
  localparam int OUT_W = 8;
  localparam int KX    = 5;
  localparam int KY    = 1;
  localparam int LAT   = IN_W + 9;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic signed [IN_W-1:0]  data_in = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [OUT_W-1:0] data_out;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic                    out_err;

  iir_inverse #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .KX   (KX),
    .KY   (8'sd1),
    .SUM_W(IN_W + 9)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int m_prev = 0;

  typedef struct {
    bit do_rst;
    int y;
    int exp_q;
    bit exp_err;
    int stall;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    m_prev = 0;
  endtask

  // Reference: exact arithmetic on the recovery formula, truncation toward zero.
  task automatic model(input int y, output int q, output bit e);
    longint s, qq;
    s  = longint'(y) + longint'(KY) * longint'(m_prev);
    qq = s / KX;
    e  = (s % KX) != 0;
    if (qq > 127) begin
      qq = 127;
      e  = 1'b1;
    end else if (qq < -128) begin
      qq = -128;
      e  = 1'b1;
    end
    q = int'(qq);
  endtask

  task automatic send(input string tag, input int y, input int exp_q, input bit exp_err,
                      input int stall);
    int lat;
    logic signed [OUT_W-1:0] d0;
    logic e0;
    check({tag, " in_ready_idle"}, longint'(in_ready), 1);
    in_valid  = 1'b1;
    data_in   = IN_W'(y);
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    data_in  = IN_W'($urandom);
    lat = 0;
    while (!out_valid && lat < LAT + 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, LAT);
    check({tag, " data_out"}, longint'(data_out), exp_q);
    check({tag, " out_err"}, longint'(out_err), longint'(exp_err));
    m_prev = y;
    d0 = data_out;
    e0 = out_err;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      data_in  = IN_W'($urandom);
      tick();
      check({tag, " stall out_valid"}, longint'(out_valid), 1);
      check({tag, " stall data_out"}, longint'(data_out), longint'(d0));
      check({tag, " stall out_err"}, longint'(out_err), longint'(e0));
      check({tag, " stall in_ready"}, longint'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check({tag, " post out_valid"}, longint'(out_valid), 0);
    check({tag, " post in_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int q;
    bit e;
    int fx_prev, fy_prev, x, y;
    bit seen;

    tbl[0] = '{1'b1,   -35,   -7, 1'b0,  0};
    tbl[1] = '{1'b0,     5,   -6, 1'b0,  0};
    tbl[2] = '{1'b0,   -20,   -3, 1'b0,  0};
    tbl[3] = '{1'b1,     7,    1, 1'b1,  0};
    tbl[4] = '{1'b0,    -7,    0, 1'b0,  0};
    tbl[5] = '{1'b1,  1000,  127, 1'b1,  0};
    tbl[6] = '{1'b0, -2000, -128, 1'b1,  0};
    tbl[7] = '{1'b0,  2010,    2, 1'b0, 10};

    do_reset();
    check("reset in_ready", longint'(in_ready), 1);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset data_out", longint'(data_out), 0);
    check("reset out_err", longint'(out_err), 0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].do_rst) do_reset();
      send($sformatf("tbl%0d", i), tbl[i].y, tbl[i].exp_q, tbl[i].exp_err, tbl[i].stall);
      $display("vec tbl%0d y=%0d data_out=%0d out_err=%0d", i, tbl[i].y, data_out, out_err);
    end

    // Reset on the 10th cycle of a division must drop the result and y_prev.
    do_reset();
    in_valid  = 1'b1;
    data_in   = IN_W'(-35);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    do_reset();
    check("abort in_ready", longint'(in_ready), 1);
    check("abort out_valid", longint'(out_valid), 0);
    seen = 1'b0;
    for (int i = 0; i < LAT + 10; i++) begin
      seen |= out_valid;
      tick();
    end
    check("abort no output", longint'(seen), 0);
    send("abort_next", 10, 2, 1'b0, 0);
    $display("vec abort_next y=10 data_out=%0d out_err=%0d", data_out, out_err);

    // Random raw samples against the arithmetic model, with random backpressure.
    for (int i = 0; i < 20; i++) begin
      y = int'($urandom_range(0, 2 ** IN_W - 1)) - 2 ** (IN_W - 1);
      model(y, q, e);
      send($sformatf("rnd%0d", i), y, q, e, int'($urandom_range(0, 3)));
      $display("vec rnd%0d y=%0d exp=%0d/%0d", i, y, q, e);
    end

    // Filter-driven stream: each output recovers the previous filter input.
    do_reset();
    fx_prev = 0;
    fy_prev = 0;
    for (int i = 0; i < 30; i++) begin
      x = int'($urandom_range(0, 14)) - 7;
      y = KX * fx_prev - KY * fy_prev;
      send($sformatf("flt%0d", i), y, fx_prev, 1'b0, 0);
      $display("vec flt%0d y=%0d exp_x=%0d", i, y, fx_prev);
      fx_prev = x;
      fy_prev = y;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/iir_inverse.md
Name: iir_inverse

Overview:
- Inverse (deconvolution) stage for the first-order IIR filter path, defined by y[n] = KX*x[n-1] - KY*y[n-1].
- Takes the filter's output sample stream and recovers the original 8-bit input samples using x = (y[n] + KY*y[n-1]) / KX.
- Uses a bit-serial restoring divider with valid/ready handshakes on both sides.
- Sits downstream of the filter on the loopback/verification path.

Parameters:
- IN_W, 18, width of the signed input sample (the filter output width).
- OUT_W, 8, width of the signed recovered sample.
- KX, 5, forward gain of the filter. Must be > 0; elaboration error otherwise.
- KY, 1, feedback gain of the filter, signed 8-bit.
- SUM_W, IN_W+9, width of the internal sum and of the divider (27 by default).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  IN_W  signed filter output sample y.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block can accept a sample.
- data_out  output  OUT_W  signed recovered sample x.
- out_valid  output  1  data_out and out_err are valid.
- out_ready  input  1  consumer accepts the output.
- out_err  output  1  result was inexact (nonzero remainder) or saturated.

Behaviour:
- Reset, sampled at a clk edge with rst=1:
  - state=IDLE, y_prev=0, data_out=0, out_valid=0, out_err=0, in_ready=1.
  - rst overrides everything. A reset during DIV or OUT aborts the operation and drops the pending result without presenting it.
- States:
  - IDLE -> DIV on an accept edge (in_valid & in_ready).
  - DIV -> OUT after SUM_W iterations.
  - OUT -> IDLE on an output-handshake edge (out_valid & out_ready).
- in_ready = (state==IDLE). There is no input/output overlap, so at most one sample is in flight.
- Accept edge:
  - s = data_in + KY*y_prev, computed at full SUM_W signed width with no overflow possible.
  - Store sign(s) and |s| in the dividend register.
  - Set y_prev <= data_in. The raw input is stored, not the sum.
  - Clear the quotient, remainder and iteration counter.
- DIV: one restoring step per clock, MSB first.
  - rem = {rem, dividend MSB}; if rem >= KX then rem -= KX and the quotient bit is 1.
  - Exactly SUM_W steps. The edge that performs step SUM_W moves the state to OUT.
- Latency: the accept edge is edge 0 and out_valid is high immediately after edge SUM_W, i.e. 27 clocks at default parameters.
- Result formation, on the transition into OUT:
  - q = quotient, negated if s < 0. This truncates toward zero.
  - If q > 2^(OUT_W-1)-1, data_out = 2^(OUT_W-1)-1 and the saturation flag is set.
  - If q < -2^(OUT_W-1), data_out = -2^(OUT_W-1) and the saturation flag is set.
  - out_err = (rem != 0) | saturation flag.
- OUT: data_out, out_valid and out_err are held stable while out_ready=0. Backpressure is unlimited.
- y_prev updates only on accepted samples. Stall cycles and idle cycles do not disturb it.
- s == 0 gives data_out=0 and out_err=0.
- Outputs are registered. No combinational path from inputs to outputs except in_ready, which depends on state only.

Test Plan:
- Reset, then feed y = -35, 5, -20 (out_ready=1) -> data_out = -7, -6, -3; out_err = 0 each; out_valid rises exactly 27 clocks after each accept edge.
- Reset, then feed y = 7 -> data_out = 1, out_err = 1 (remainder 2). Then feed y = -7 -> (-7+7)/5, so data_out = 0, out_err = 0.
- Reset, then feed y = 1000 -> data_out = 127, out_err = 1. Then feed y = -2000 -> (-2000+1000)/5 = -200, so data_out = -128, out_err = 1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> data_out, out_err and out_valid are stable; in_ready=0 and in_valid is ignored throughout; one output handshake then returns the block to IDLE.
- Reset mid-DIV, on the 10th cycle after accepting y=-35 -> out_valid never rises for that sample; in_ready=1 the cycle after reset; y_prev=0, so a next input of y=10 gives data_out = 2.
- Random filter-driven stream: x in -7..7 through a reference model of the filter, outputs fed here -> recovered sequence equals x with out_err=0 for every sample.
